// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, counter width.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: load extraction/extension, store byte enables, alignment flag.
// Alignment/size checking is present only when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_ext_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wr_word_o,
    output logic        misalign_o
);

    // Lane k of rd_word_i/wr_word_o always maps to byte address addr+k.
    always_comb begin
        misalign_o = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        case (size_i)
            SIZE_BYTE: misalign_o = 1'b0;
            SIZE_HALF: misalign_o = addr_lo_i[0];
            SIZE_WORD: misalign_o = |addr_lo_i;
            default:   misalign_o = 1'b1;
        endcase
`endif
        case (size_i)
            SIZE_BYTE: begin
                byte_en_o = 4'b0001;
                ld_data_o = {{24{sign_ext_i & rd_word_i[7]}}, rd_word_i[7:0]};
            end
            SIZE_HALF: begin
                byte_en_o = 4'b0011;
                ld_data_o = {{16{sign_ext_i & rd_word_i[15]}}, rd_word_i[15:0]};
            end
            default: begin
                byte_en_o = 4'b1111;
                ld_data_o = rd_word_i;
            end
        endcase
        if (misalign_o) begin
            byte_en_o = '0;
            ld_data_o = '0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            wr_word_o[8*k +: 8] = byte_en_o[k] ? wdata_i[8*k +: 8] : 8'h00;
        end
    end

`ifndef DMEM_MISALIGN_CHECK_EN
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_lo_i;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked fixed-latency data-memory responder over little-endian byte storage.
// Define DMEM_MISALIGN_CHECK_EN to enable alignment/size error detection.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int LATENCY       = 2
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_sign_ext,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [1:0]               size_q;
    logic                     sext_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic [7:0]               mem_q [DEPTH];

    logic [ADDRESS_WIDTH-1:0] lane_addr [4];
    logic [31:0]              rd_word, ld_data, wr_word;
    logic [3:0]               byte_en;
    logic                     misalign;
    logic                     execute;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            lane_addr[k]       = addr_q + ADDRESS_WIDTH'(k);
            rd_word[8*k +: 8]  = mem_q[lane_addr[k]];
        end
    end

    dmem_lane_align u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .sign_ext_i (sext_q),
        .rd_word_i  (rd_word),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .byte_en_o  (byte_en),
        .wr_word_o  (wr_word),
        .misalign_o (misalign)
    );

    // Every accept passes through WAIT; reaching zero there lands RESP exactly LATENCY edges after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        execute = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: if (cnt_q == '0) begin
                state_d = RESP;
                execute = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                sext_q  <= req_sign_ext;
                wdata_q <= req_wdata;
            end
            if (execute) begin
                err_q   <= misalign;
                rdata_q <= we_q ? '0 : ld_data;
                if (we_q) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (byte_en[k]) mem_q[lane_addr[k]] <= wr_word[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed test-plan cases plus a random load/store mix.
module tb_data_mem_responder;

    localparam int LAT = 2;

    typedef struct packed {
        logic [7:0]  lat;
        logic        err;
        logic [31:0] rdata;
        logic        post_valid;
        logic        post_ready;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } stim_t;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sign_ext;
    logic [3:0]  req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int   n_checks = 0;
    int   n_pass   = 0;
    rsp_t exp_q[$];
    logic [7:0] mdl_mem [16];

    always #5 CLK = ~CLK;

    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .LATENCY(LAT)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_sign_ext(req_sign_ext),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    function automatic rsp_t mk_rsp(input logic [31:0] d, input logic err);
        rsp_t r;
        r.lat = 8'(LAT); r.err = err; r.rdata = d; r.post_valid = 1'b0; r.post_ready = 1'b1;
        return r;
    endfunction

    function automatic string fmt(input rsp_t r);
        return $sformatf("lat=%0d err=%b rdata=%h post_valid=%b post_ready=%b",
                         r.lat, r.err, r.rdata, r.post_valid, r.post_ready);
    endfunction

    // Reference memory: byte-wise little-endian access with address wrap.
    task automatic model_calc(input logic we, input logic [3:0] addr, input logic [1:0] size,
                              input logic sext, input logic [31:0] wdata, output rsp_t r);
        int unsigned n;
        logic [31:0] rd;
        logic [3:0]  a;
        logic        bad;
        r = mk_rsp(32'h0, 1'b0);
        bad = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`endif
        if (bad) begin
            r.err = 1'b1;
            return;
        end
        n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        rd = '0;
        for (int unsigned k = 0; k < n; k++) begin
            a = addr + 4'(k);
            if (we) mdl_mem[a] = wdata[8*k +: 8];
            else    rd[8*k +: 8] = mdl_mem[a];
        end
        if (!we) begin
            if (sext && n == 1) rd[31:8]  = {24{rd[7]}};
            if (sext && n == 2) rd[31:16] = {16{rd[15]}};
            r.rdata = rd;
        end
    endtask

    // Drives one request from IDLE, lets the response handshake immediately, reports what was seen.
    task automatic send(input logic we, input logic [3:0] addr, input logic [1:0] size,
                        input logic sext, input logic [31:0] wdata, output rsp_t r);
        int lat;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_sign_ext = sext; req_wdata = wdata; rsp_ready = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 4'($urandom);
        req_size = 2'($urandom); req_sign_ext = 1'($urandom); req_wdata = $urandom;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        r.lat = 8'(lat); r.err = rsp_err; r.rdata = rsp_rdata;
        @(posedge CLK); #1;
        r.post_valid = rsp_valid; r.post_ready = req_ready;
    endtask

    task automatic test_reset();
        rsp_t r, e, m;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'h0})
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        else n_pass++;
        rst = 1'b0;
        model_calc(1'b0, 4'd0, 2'b10, 1'b0, 32'h0, m);
        exp_q.push_back(mk_rsp(32'h0, 1'b0));
        send(1'b0, 4'd0, 2'b10, 1'b0, 32'h0, r);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) $display("FAIL reset_load0: got %s, expected %s", fmt(r), fmt(e));
        else n_pass++;
    endtask

    task automatic test_misalign();
        stim_t t[4];
        rsp_t  r, e, m;
`ifdef DMEM_MISALIGN_CHECK_EN
        t[0] = '{1'b1, 4'd2, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0, 1'b1};
        t[1] = '{1'b0, 4'd0, 2'b10, 1'b0, 32'h0,        32'h0, 1'b0};
        t[2] = '{1'b0, 4'd1, 2'b01, 1'b0, 32'h0,        32'h0, 1'b1};
        t[3] = '{1'b0, 4'd0, 2'b11, 1'b0, 32'h0,        32'h0, 1'b1};
`else
        t[0] = '{1'b1, 4'd2, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0,        1'b0};
        t[1] = '{1'b0, 4'd0, 2'b10, 1'b0, 32'h0,        32'hBABE0000, 1'b0};
        t[2] = '{1'b0, 4'd1, 2'b01, 1'b0, 32'h0,        32'h0000BE00, 1'b0};
        t[3] = '{1'b0, 4'd0, 2'b11, 1'b0, 32'h0,        32'hBABE0000, 1'b0};
`endif
        foreach (t[i]) begin
            model_calc(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, m);
            exp_q.push_back(mk_rsp(t[i].exp, t[i].err));
            send(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, r);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) $display("FAIL misalign[%0d]: got %s, expected %s", i, fmt(r), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_store_load();
        stim_t t[4];
        rsp_t  r, e, m;
        t[0] = '{1'b1, 4'd4, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        t[1] = '{1'b0, 4'd5, 2'b00, 1'b1, 32'h0,        32'hFFFFFFBE, 1'b0};
        t[2] = '{1'b0, 4'd6, 2'b01, 1'b0, 32'h0,        32'h0000DEAD, 1'b0};
        t[3] = '{1'b0, 4'd7, 2'b00, 1'b0, 32'h0,        32'h000000DE, 1'b0};
        foreach (t[i]) begin
            model_calc(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, m);
            exp_q.push_back(mk_rsp(t[i].exp, t[i].err));
            send(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, r);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) $display("FAIL store_load[%0d]: got %s, expected %s", i, fmt(r), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_byte_merge();
        stim_t t[4];
        rsp_t  r, e, m;
        t[0] = '{1'b1, 4'd8, 2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0};
        t[1] = '{1'b1, 4'd9, 2'b00, 1'b0, 32'h777777A5, 32'h0,        1'b0};
        t[2] = '{1'b0, 4'd8, 2'b10, 1'b0, 32'h0,        32'h1122A544, 1'b0};
        t[3] = '{1'b0, 4'd4, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        foreach (t[i]) begin
            model_calc(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, m);
            exp_q.push_back(mk_rsp(t[i].exp, t[i].err));
            send(t[i].we, t[i].addr, t[i].size, t[i].sext, t[i].wdata, r);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) $display("FAIL byte_merge[%0d]: got %s, expected %s", i, fmt(r), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        rsp_t r, e, m;
        int   lat;
        model_calc(1'b0, 4'd4, 2'b10, 1'b0, 32'h0, m);
        exp_q.push_back(mk_rsp(32'hDEADBEEF, 1'b0));
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4; req_size = 2'b10;
        req_sign_ext = 1'b0; rsp_ready = 1'b0;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        r.lat = 8'(lat); r.err = rsp_err; r.rdata = rsp_rdata;
        e = exp_q.pop_front();
        n_checks++;
        if ({r.lat, r.err, r.rdata} !== {e.lat, e.err, e.rdata})
            $display("FAIL bp_first: got lat=%0d err=%b rdata=%h, expected lat=%0d err=%b rdata=%h",
                     r.lat, r.err, r.rdata, e.lat, e.err, e.rdata);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 4'($urandom); req_wdata = $urandom;
            @(posedge CLK); #1;
            n_checks++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {3'b100, e.rdata})
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b err=%b rdata=%h, expected 1 0 0 %h",
                         i, rsp_valid, req_ready, rsp_err, rsp_rdata, e.rdata);
            else n_pass++;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL bp_release: got valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rsp_t r, e;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd12; req_size = 2'b10; req_wdata = 32'h55AA55AA;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL rst_mid_async: got valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
        else n_pass++;
        @(posedge CLK); #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL rst_mid_hold: got valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
        else n_pass++;
        rst = 1'b0;
        exp_q.push_back(mk_rsp(32'h0, 1'b0));
        send(1'b0, 4'd12, 2'b10, 1'b0, 32'h0, r);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) $display("FAIL rst_mid_load: got %s, expected %s", fmt(r), fmt(e));
        else n_pass++;
    endtask

    task automatic test_random();
        rsp_t        r, e;
        logic        we, sext;
        logic [3:0]  addr;
        logic [1:0]  size;
        logic [31:0] wd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom); addr = 4'($urandom); size = 2'($urandom);
            sext = 1'($urandom); wd = $urandom;
            model_calc(we, addr, size, sext, wd, e);
            exp_q.push_back(e);
            send(we, addr, size, sext, wd, r);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e)
                $display("FAIL random[%0d] we=%b addr=%0d size=%b: got %s, expected %s",
                         i, we, addr, size, fmt(r), fmt(e));
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_sign_ext = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_misalign();
        test_store_load();
        test_byte_merge();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
